// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state, length and requester encodings for mem_ctrl
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_ISSUE = 2'd1,
        MC_DRAIN = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_t;

    typedef enum logic {
        SEL_IF  = 1'b0,
        SEL_MEM = 1'b1
    } mc_sel_t;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // The reserved code 2'b11 behaves as a word transfer.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-bus memory controller arbitrating instruction fetch and load/store
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (0 = freeze everything)
//   if_req_i/if_addr_i/flush_i      -> if_done_o/if_data_o        4-byte fetch port
//   mem_req_i/we/len/addr/wdata     -> mem_done_o/mem_rdata_o     load/store port
//   mem_din / mem_dout / mem_a / mem_wr                           external byte bus
//   busy_o                                                        high outside IDLE
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BYTES  = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    flush_i,
    output logic                    if_done_o,
    output logic [8*MAX_BYTES-1:0]  if_data_o,
    input  logic                    mem_req_i,
    input  logic                    mem_we_i,
    input  logic [1:0]              mem_len_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [8*MAX_BYTES-1:0]  mem_wdata_i,
    output logic                    mem_done_o,
    output logic [8*MAX_BYTES-1:0]  mem_rdata_o,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    output logic                    busy_o
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int KW = 3;                  // holds 0..MAX_BYTES
    localparam int IW = $clog2(MAX_BYTES);  // byte lane index

    mc_state_t              r_state;
    mc_state_t              w_state_next;
    mc_sel_t                r_sel;
    logic                   r_we;
    logic [KW-1:0]          r_n;
    logic [KW-1:0]          r_k;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  r_last_a;
    logic [DW-1:0]          r_wdata;
    logic [DW-1:0]          r_buf;
    logic [DW-1:0]          r_if_data;
    logic [DW-1:0]          r_mem_data;

    logic                   w_accept_mem;
    logic                   w_accept_if;
    logic                   w_flush_if;
    logic                   w_capture;
    logic                   w_if_done;
    logic                   w_mem_done;
    logic [IW-1:0]          w_k_idx;
    logic [IW-1:0]          w_cap_idx;
    logic [ADDR_WIDTH-1:0]  w_mem_a;

    assign w_k_idx    = r_k[IW-1:0];
    // mem_din in the cycle after issuing byte k carries byte k, so the byte
    // arriving now belongs to the previous counter value.
    assign w_cap_idx  = IW'(r_k - KW'(1));
    assign w_flush_if = flush_i && (r_sel == SEL_IF) && (r_state != MC_IDLE);
    assign w_capture  = rdy_in && !r_we &&
                        (((r_state == MC_ISSUE) && (r_k != '0)) || (r_state == MC_DRAIN));
    assign w_if_done  = rdy_in && (r_state == MC_DONE) && (r_sel == SEL_IF) && !flush_i;
    assign w_mem_done = rdy_in && (r_state == MC_DONE) && (r_sel == SEL_MEM);

    always_comb begin
        w_state_next = r_state;
        w_accept_mem = 1'b0;
        w_accept_if  = 1'b0;
        if (rdy_in) begin
            case (r_state)
                MC_IDLE: begin
                    if (mem_req_i) begin
                        w_accept_mem = 1'b1;
                        w_state_next = MC_ISSUE;
                    end else if (if_req_i && !flush_i) begin
                        w_accept_if  = 1'b1;
                        w_state_next = MC_ISSUE;
                    end
                end
                MC_ISSUE: begin
                    if (r_k == r_n - KW'(1)) begin
                        w_state_next = r_we ? MC_DONE : MC_DRAIN;
                    end
                end
                MC_DRAIN: w_state_next = MC_DONE;
                MC_DONE:  w_state_next = MC_IDLE;
                default:  w_state_next = MC_IDLE;
            endcase
            if (w_flush_if) begin
                w_state_next = MC_IDLE;
            end
        end
    end

    always_comb begin
        w_mem_a   = '0;
        mem_wr    = 1'b0;
        mem_dout  = '0;
        // While paused, keep presenting the last issued address so the RAM
        // keeps returning the byte that will be captured on resume.
        if (!rdy_in) begin
            w_mem_a = r_last_a;
        end else if (r_state == MC_ISSUE) begin
            w_mem_a = r_addr + ADDR_WIDTH'(r_k);
            mem_wr  = r_we;
        end
        if ((r_state == MC_ISSUE) && r_we) begin
            mem_dout = r_wdata[8*w_k_idx +: 8];
        end
        mem_a       = w_mem_a;
        if_done_o   = w_if_done;
        mem_done_o  = w_mem_done;
        if_data_o   = w_if_done ? r_buf : r_if_data;
        mem_rdata_o = (w_mem_done && !r_we) ? r_buf : r_mem_data;
        busy_o      = (r_state != MC_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= MC_IDLE;
            r_sel      <= SEL_IF;
            r_we       <= 1'b0;
            r_n        <= '0;
            r_k        <= '0;
            r_addr     <= '0;
            r_last_a   <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_if_data  <= '0;
            r_mem_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (rdy_in) begin
                r_last_a <= w_mem_a;
            end
            if (w_accept_mem || w_accept_if) begin
                r_sel   <= w_accept_mem ? SEL_MEM : SEL_IF;
                r_we    <= w_accept_mem && mem_we_i;
                r_n     <= w_accept_mem ? len_to_bytes(mem_len_i) : KW'(MAX_BYTES);
                r_addr  <= w_accept_mem ? mem_addr_i : if_addr_i;
                r_wdata <= mem_wdata_i;
                r_k     <= '0;
                r_buf   <= '0;
            end else if (rdy_in && (r_state == MC_ISSUE)) begin
                r_k <= r_k + KW'(1);
            end
            if (w_capture) begin
                r_buf[8*w_cap_idx +: 8] <= mem_din;
            end
            if (w_if_done) begin
                r_if_data <= r_buf;
            end
            if (w_mem_done && !r_we) begin
                r_mem_data <= r_buf;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a transaction-level model
module tb_mem_ctrl;

    localparam int RAM_BYTES = 131072;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, if_req_i, flush_i, mem_req_i, mem_we_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
    logic [1:0]  mem_len_i;
    logic        if_done_o, mem_done_o, mem_wr, busy_o;
    logic [31:0] if_data_o, mem_rdata_o, mem_a;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  ram     [RAM_BYTES];
    logic [7:0]  ref_ram [RAM_BYTES];
    logic        seed_en;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_if_data;
    logic [31:0] last_mem_data;
    bit          mem_data_known;

    mem_ctrl #(.ADDR_WIDTH(32), .MAX_BYTES(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
        .if_done_o(if_done_o), .if_data_o(if_data_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .busy_o(busy_o)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] seed_byte(input int i);
        if (i == 'h100) return 8'h13;
        if (i == 'h101) return 8'h05;
        if (i == 'h102 || i == 'h103) return 8'h00;
        if (i == 'h30) return 8'h80;
        return 8'((i * 37) ^ (i >> 5));
    endfunction

    // External RAM: address presented in cycle t, byte on mem_din in cycle t+1.
    always @(posedge clk_in) begin
        if (seed_en) begin
            for (int i = 0; i < RAM_BYTES; i++) ram[i] <= seed_byte(i);
        end else if (mem_wr) begin
            ram[mem_a[16:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[16:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_a"}, mem_a, 0);
        check({tag, "_mem_dout"}, 32'(mem_dout), 0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 0);
        check({tag, "_if_done"}, 32'(if_done_o), 0);
        check({tag, "_mem_done"}, 32'(mem_done_o), 0);
        check({tag, "_if_data"}, if_data_o, 0);
        check({tag, "_mem_rdata"}, mem_rdata_o, 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    // One transaction accepted in the current (idle) cycle A. The model counts
    // ready cycles j after A: byte j-1 goes out on cycles j=1..n, the done
    // pulse lands on j=n+2 for reads and j=n+1 for writes.
    task automatic run_txn(input bit is_if, input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ps, input int pl, input int fl_c,
                           input bit also_if, input logic [31:0] also_addr);
        int          n, n_end, j;
        bit          last_issue, done_exp, wr;
        logic [31:0] exp_data, last_a, a_b;
        wr    = !is_if && we;
        n     = is_if ? 4 : (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        n_end = wr ? n + 1 : n + 2;
        exp_data = '0;
        for (int b = 0; b < n; b++) begin
            a_b = addr + 32'(b);
            if (!wr) exp_data[8*b +: 8] = ref_ram[a_b[16:0]];
        end
        check("idle_busy", 32'(busy_o), 0);
        check("if_data_hold", if_data_o, last_if_data);
        if (mem_data_known) check("mem_rdata_hold", mem_rdata_o, last_mem_data);
        rdy_in  = 1'b1;
        flush_i = 1'b0;
        if (is_if) begin
            if_req_i = 1'b1; if_addr_i = addr;
        end else begin
            mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len;
            mem_addr_i = addr; mem_wdata_i = wdata;
        end
        if (also_if) begin
            if_req_i = 1'b1; if_addr_i = also_addr;
        end
        j = 0; last_issue = 0; last_a = '0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk_in); #1;
            rdy_in  = !(c >= ps && c < ps + pl);
            flush_i = (c == fl_c);
            if (c == 2) begin
                if (is_if) if_addr_i = $urandom;
                else begin
                    mem_we_i = 1'($urandom); mem_len_i = 2'($urandom);
                    mem_addr_i = $urandom; mem_wdata_i = $urandom;
                end
            end
            #1;
            if (rdy_in) j++;
            done_exp = rdy_in && (j == n_end);
            if (rdy_in && j <= n) begin
                check("bus_addr", mem_a, addr + 32'(j - 1));
                check("bus_wr", 32'(mem_wr), 32'(wr));
                if (wr) check("bus_dout", 32'(mem_dout), 32'(wdata[8*(j-1) +: 8]));
                last_a = addr + 32'(j - 1);
                last_issue = 1;
            end else begin
                check("bus_wr_off", 32'(mem_wr), 0);
                if (!rdy_in && last_issue) check("pause_addr", mem_a, last_a);
                if (rdy_in) last_issue = 0;
            end
            check("busy", 32'(busy_o), 1);
            check("if_done", 32'(if_done_o), 32'(is_if && done_exp));
            check("mem_done", 32'(mem_done_o), 32'(!is_if && done_exp));
            if (done_exp) begin
                if (is_if) begin
                    check("if_data", if_data_o, exp_data);
                    last_if_data = exp_data;
                    if_req_i = 1'b0;
                end else if (!we) begin
                    check("mem_rdata", mem_rdata_o, exp_data);
                    last_mem_data = exp_data;
                    mem_data_known = 1;
                    mem_req_i = 1'b0;
                end else begin
                    for (int b = 0; b < n; b++) begin
                        a_b = addr + 32'(b);
                        ref_ram[a_b[16:0]] = wdata[8*b +: 8];
                    end
                    mem_data_known = 0;
                    mem_req_i = 1'b0;
                end
                break;
            end
        end
        flush_i = 1'b0;
        rdy_in  = 1'b1;
        @(posedge clk_in); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          kind, ps, pl, fl_c, ndiff;
        logic [31:0] addr;
        logic [31:0] rst_wdata;
        rst_in = 1'b1; seed_en = 1'b1; rdy_in = 1'b1; flush_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_len_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
        last_if_data = '0; last_mem_data = '0; mem_data_known = 1;
        for (int i = 0; i < RAM_BYTES; i++) ref_ram[i] = seed_byte(i);
        repeat (3) @(posedge clk_in);
        #1; seed_en = 1'b0; #1;
        check_zero("reset");
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Fetch 0x100 -> 0x00000513; word store; simultaneous load+fetch.
        run_txn(1, 0, 2'b10, 32'h100, 0, 100, 0, 0, 0, 0);
        check("fetch_0x100", last_if_data, 32'h0000_0513);
        run_txn(0, 1, 2'b10, 32'h2000, 32'hDEAD_BEEF, 100, 0, 0, 0, 0);
        run_txn(0, 0, 2'b00, 32'h30, 0, 100, 0, 0, 1, 32'h100);
        check("load_0x30", last_mem_data, 32'h0000_0080);
        run_txn(1, 0, 2'b10, 32'h100, 0, 100, 0, 0, 0, 0);
        // Pause for 3 cycles right after byte 1 of a fetch is issued.
        run_txn(1, 0, 2'b10, 32'h2000, 0, 3, 3, 0, 0, 0);
        check("readback_store", last_if_data, 32'hDEAD_BEEF);

        // Flush while idle blocks the fetch.
        if_req_i = 1'b1; if_addr_i = 32'h100; flush_i = 1'b1;
        @(posedge clk_in); #1;
        if_req_i = 1'b0; flush_i = 1'b0; #1;
        check("flush_idle_block", 32'(busy_o), 0);

        // Flush in cycle A+3 of a fetch.
        if_req_i = 1'b1; if_addr_i = 32'h200;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk_in); #1;
            flush_i = (c == 3);
            if (c == 4) if_req_i = 1'b0;
            #1;
            check("flush_no_done", 32'(if_done_o), 0);
            if (c == 4) begin
                check("flush_to_idle", 32'(busy_o), 0);
                check("flush_addr", mem_a, 0);
            end
        end
        flush_i = 1'b0;
        check("flush_data_hold", if_data_o, last_if_data);
        run_txn(1, 0, 2'b10, 32'h200, 0, 100, 0, 0, 0, 0);

        // Reset in the third cycle of a word store: bytes 0..2 reach the bus.
        rst_wdata = 32'hA1B2_C3D4;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
        mem_addr_i = 32'h3000; mem_wdata_i = rst_wdata;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk_in); #1;
            rst_in = (c == 3);
            if (c == 4) mem_req_i = 1'b0;
            #1;
            check("rst_no_done", 32'(mem_done_o), 0);
            if (c == 4) check_zero("post_rst");
        end
        for (int b = 0; b < 3; b++) ref_ram['h3000 + b] = rst_wdata[8*b +: 8];
        last_if_data = '0; last_mem_data = '0; mem_data_known = 1;
        run_txn(0, 1, 2'b01, 32'h3001, 32'h0000_5A6B, 100, 0, 0, 0, 0);
        run_txn(0, 0, 2'b10, 32'h3000, 0, 100, 0, 0, 0, 0);

        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 2);
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                               : 32'h4000 + 32'($urandom_range(0, 63));
            ps   = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : 100;
            pl   = $urandom_range(1, 4);
            fl_c = (kind != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            run_txn(kind == 0, kind == 2, 2'($urandom), addr, $urandom, ps, pl, fl_c, 0, 0);
        end

        ndiff = 0;
        for (int i = 0; i < RAM_BYTES; i++) if (ram[i] !== ref_ram[i]) ndiff++;
        check("ram_image_diffs", 32'(ndiff), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
